// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-priority (load/store over fetch) arbiter for a byte-wide memory
// port. Each granted 1/2/4-byte transfer is serialised into consecutive bus cycles.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        flush,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [1:0]  ls_mask,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  output logic        busy
);

  localparam logic [31:0] IO_ADDR  = 32'h0003_0000;
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_READ  = 2'd1;
  localparam logic [1:0]  ST_WRITE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  n_q, n_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        is_ls_q, is_ls_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic        stall_q, stall_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        if_done_q, if_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic        ls_done_q, ls_done_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;
  logic        busy_q, busy_d;
  logic [2:0]  cnt_nxt_s;

  // Byte count of a load/store; IO-port loads are always single byte.
  function automatic logic [2:0] ls_len(input logic we, input logic [31:0] a,
                                        input logic [1:0] mask);
    logic [2:0] len;
    if (!we && (a == IO_ADDR)) begin
      len = 3'd1;
    end else begin
      case (mask)
        2'b10:   len = 3'd2;
        2'b11:   len = 3'd4;
        default: len = 3'd1;
      endcase
    end
    return len;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      2'd3:    r[31:24] = b;
      default: r = w;
    endcase
    return r;
  endfunction

  assign cnt_nxt_s = cnt_q + 3'd1;

  // Next-state logic: grant in IDLE, then sequence one byte per ready cycle.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    is_ls_d    = is_ls_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    stall_d    = stall_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = 1'b0;
    if_done_d  = 1'b0;
    if_data_d  = if_data_q;
    ls_done_d  = 1'b0;
    ls_rdata_d = ls_rdata_q;
    if (!rdy_in) begin
      // A write cycle cut short by a freeze is replayed on resume.
      stall_d = (state_q == ST_WRITE);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ls_req) begin
            addr_d  = ls_addr;
            n_d     = ls_len(ls_we, ls_addr, ls_mask);
            cnt_d   = 3'd0;
            is_ls_d = 1'b1;
            wdata_d = ls_wdata;
            data_d  = 32'd0;
            mem_a_d = ls_addr;
            if (ls_we) begin
              state_d    = ST_WRITE;
              mem_wr_d   = 1'b1;
              mem_dout_d = ls_wdata[7:0];
            end else begin
              state_d = ST_READ;
            end
          end else if (if_req && !flush) begin
            addr_d  = if_addr;
            n_d     = 3'd4;
            cnt_d   = 3'd0;
            is_ls_d = 1'b0;
            data_d  = 32'd0;
            mem_a_d = if_addr;
            state_d = ST_READ;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_READ: begin
          if (flush && !is_ls_q) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_nxt_s;
            if (cnt_nxt_s < n_q) begin
              mem_a_d = addr_q + {29'd0, cnt_nxt_s};
            end else begin
              mem_a_d = mem_a_q;
            end
            // mem_din holds the byte addressed two ready edges ago.
            if (cnt_q != 3'd0) begin
              data_d = put_byte(data_q, cnt_q[1:0] - 2'd1, mem_din);
            end else begin
              data_d = data_q;
            end
            if (cnt_q == n_q) begin
              state_d = ST_IDLE;
              if (is_ls_q) begin
                ls_done_d  = 1'b1;
                ls_rdata_d = data_d;
              end else begin
                if_done_d = 1'b1;
                if_data_d = data_d;
              end
            end else begin
              state_d = ST_READ;
            end
          end
        end
        ST_WRITE: begin
          if (stall_q) begin
            mem_wr_d = 1'b1;
            stall_d  = 1'b0;
          end else if (cnt_nxt_s < n_q) begin
            cnt_d      = cnt_nxt_s;
            mem_a_d    = addr_q + {29'd0, cnt_nxt_s};
            mem_dout_d = get_byte(wdata_q, cnt_nxt_s[1:0]);
            mem_wr_d   = 1'b1;
          end else begin
            ls_done_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= 32'd0;
      n_q        <= 3'd0;
      cnt_q      <= 3'd0;
      is_ls_q    <= 1'b0;
      wdata_q    <= 32'd0;
      data_q     <= 32'd0;
      stall_q    <= 1'b0;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      if_data_q  <= 32'd0;
      ls_done_q  <= 1'b0;
      ls_rdata_q <= 32'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      is_ls_q    <= is_ls_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      stall_q    <= stall_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_done_q  <= if_done_d;
      if_data_q  <= if_data_d;
      ls_done_q  <= ls_done_d;
      ls_rdata_q <= ls_rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q;
  assign if_done  = if_done_q;
  assign if_data  = if_data_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed + randomized bench with a RAM model, a byte-level reference
// memory and a scoreboard monitor for fetch results, load/store results and bus writes.
module tb_mem_arbiter;

  localparam logic [31:0] IO_ADDR = 32'h0003_0000;

  logic        clk = 1'b0;
  logic        rst, rdy_in, if_req, flush, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [1:0]  ls_mask;
  logic [7:0]  mem_din;
  logic        if_done, ls_done, mem_wr, busy;
  logic [31:0] if_data, ls_rdata, mem_a;
  logic [7:0]  mem_dout;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_mask(ls_mask), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Initial memory image; a few locations are pinned for the directed tests.
  function automatic logic [7:0] init_byte(input logic [15:0] i);
    case (i)
      16'h1000: return 8'h13;
      16'h1001: return 8'h05;
      16'h1002: return 8'h00;
      16'h1003: return 8'h00;
      16'h0010: return 8'h34;
      16'h0011: return 8'h12;
      default:  return {i[6:0] ^ i[14:8], 1'b1};
    endcase
  endfunction

  // RAM: registered read, halted with rdy_in like the arbiter.
  logic [7:0] phys  [0:65535];
  bit         wrote [0:65535];
  always @(posedge clk) begin
    if (rdy_in) begin
      if (mem_wr) begin
        phys[mem_a[15:0]]  <= mem_dout;
        wrote[mem_a[15:0]] <= 1'b1;
      end
      mem_din <= wrote[mem_a[15:0]] ? phys[mem_a[15:0]] : init_byte(mem_a[15:0]);
    end
  end

  // Reference memory contents (stores applied when issued).
  logic [7:0] ref_mem [int];
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    int k;
    k = int'(a[15:0]);
    if (ref_mem.exists(k)) return ref_mem[k];
    return init_byte(a[15:0]);
  endfunction

  typedef struct { bit st; logic [31:0] d; } ls_exp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } wr_exp_t;
  logic [31:0] if_exp_q [$];
  ls_exp_t     ls_exp_q [$];
  wr_exp_t     wr_exp_q [$];
  logic [31:0] last_ls;

  // Monitor: pops expectations whenever the DUT presents a result or commits a write.
  always @(negedge clk) begin
    logic [31:0] e;
    ls_exp_t     le;
    wr_exp_t     we_e;
    if (!rst) begin
      if (if_done) begin
        check("if_done_pending", {31'd0, if_exp_q.size() != 0}, 32'd1);
        if (if_exp_q.size() != 0) begin
          e = if_exp_q.pop_front();
          check("if_data", if_data, e);
        end
      end
      if (ls_done) begin
        check("ls_done_pending", {31'd0, ls_exp_q.size() != 0}, 32'd1);
        if (ls_exp_q.size() != 0) begin
          le = ls_exp_q.pop_front();
          if (le.st) begin
            check("ls_rdata_hold", ls_rdata, last_ls);
          end else begin
            check("ls_rdata", ls_rdata, le.d);
            last_ls = le.d;
          end
        end
      end
      if (mem_wr && rdy_in) begin
        check("wr_pending", {31'd0, wr_exp_q.size() != 0}, 32'd1);
        if (wr_exp_q.size() != 0) begin
          we_e = wr_exp_q.pop_front();
          check("wr_addr", mem_a, we_e.a);
          check("wr_byte", {24'd0, mem_dout}, {24'd0, we_e.d});
        end
      end
    end
  end

  task automatic do_fetch(input logic [31:0] a, input int exp_lat, input bit chk_addr);
    int c0;
    bit seen;
    if_exp_q.push_back({ref_rd(a + 32'd3), ref_rd(a + 32'd2), ref_rd(a + 32'd1), ref_rd(a)});
    if_addr = a;
    if_req  = 1'b1;
    c0      = cyc;
    seen    = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk); #1;
      if (chk_addr && i < 4) check("fetch_mem_a", mem_a, a + 32'(i));
      if (if_done) seen = 1'b1;
    end
    if_req = 1'b0;
    check("if_done_seen", {31'd0, seen}, 32'd1);
    if (exp_lat >= 0 && seen) check("if_latency", 32'(cyc - c0), 32'(exp_lat));
  endtask

  task automatic do_ls(input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] mask, input int exp_lat);
    int n, c0;
    bit seen;
    logic [31:0] v;
    ls_exp_t le;
    wr_exp_t w;
    if (!we && a == IO_ADDR) n = 1;
    else if (mask == 2'b11)  n = 4;
    else if (mask == 2'b10)  n = 2;
    else                     n = 1;
    v = 32'd0;
    for (int k = 0; k < n; k++) begin
      if (we) begin
        w.a = a + 32'(k);
        w.d = wd[8*k +: 8];
        wr_exp_q.push_back(w);
        ref_mem[int'(w.a[15:0])] = w.d;
      end else begin
        v[8*k +: 8] = ref_rd(a + 32'(k));
      end
    end
    le.st = we;
    le.d  = v;
    ls_exp_q.push_back(le);
    ls_we    = we;
    ls_addr  = a;
    ls_wdata = wd;
    ls_mask  = mask;
    ls_req   = 1'b1;
    c0       = cyc;
    seen     = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk); #1;
      if (ls_done) seen = 1'b1;
    end
    ls_req = 1'b0;
    check("ls_done_seen", {31'd0, seen}, 32'd1);
    if (exp_lat >= 0 && seen) check("ls_latency", 32'(cyc - c0), 32'(exp_lat));
  endtask

  bit rand_done;

  initial begin
    rst = 1'b1; rdy_in = 1'b1; if_req = 1'b0; flush = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = 32'd0; ls_addr = 32'd0; ls_wdata = 32'd0; ls_mask = 2'b00;
    last_ls = 32'd0; rand_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_ls_rdata", ls_rdata, 32'd0);
    check("rst_ctrl", {28'd0, mem_wr, if_done, ls_done, busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Word fetch with address trace; done after edge 5 of the grant.
    do_fetch(32'h0000_1000, 6, 1'b1);
    // Word store then read-back, byte store, half load, IO load with word mask.
    do_ls(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 2'b11, 5);
    do_ls(1'b0, 32'h0000_2000, 32'd0, 2'b11, 6);
    do_ls(1'b1, 32'h0000_2010, 32'h0000_00A7, 2'b00, 2);
    do_ls(1'b0, 32'h0000_0010, 32'd0, 2'b10, 4);
    do_ls(1'b0, IO_ADDR, 32'd0, 2'b11, 3);

    // Simultaneous requests: load/store first, fetch on the edge after ls_done.
    fork
      do_ls(1'b0, 32'h0000_2000, 32'd0, 2'b11, 6);
      do_fetch(32'h0000_1040, 12, 1'b0);
    join

    // Flush in IDLE blocks the fetch grant.
    if_addr = 32'h0000_1080; if_req = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    check("flush_idle_busy", {31'd0, busy}, 32'd0);
    if_req = 1'b0; flush = 1'b0;

    // Flush at edge 2 of a fetch: no done, idle next cycle.
    if_addr = 32'h0000_1100; if_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; if_req = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    do_fetch(32'h0000_1200, 6, 1'b0);

    // Three frozen cycles mid word-read stretch latency by exactly three.
    fork
      do_fetch(32'h0000_1300, 9, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1 rdy_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rdy_in = 1'b1;
      end
    join

    // Reset in the middle of a fetch: everything back to zero, no done pulse.
    if_addr = 32'h0000_1400; if_req = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; if_req = 1'b0;
    @(posedge clk); #1;
    check("midrst_mem_a", mem_a, 32'd0);
    check("midrst_data", if_data | ls_rdata, 32'd0);
    check("midrst_ctrl", {24'd0, mem_dout}, 32'd0);
    check("midrst_flags", {28'd0, mem_wr, if_done, ls_done, busy}, 32'd0);
    last_ls = 32'd0;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("post_rst_idle", {29'd0, if_done, ls_done, busy}, 32'd0);
    end

    // Randomized traffic from both requesters with random freezes.
    fork
      begin
        fork
          for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            do_fetch(32'h0000_1000 + 32'($urandom_range(0, 1023)) * 32'd4, -1, 1'b0);
          end
          for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            if ($urandom_range(0, 7) == 0)
              do_ls(1'b0, IO_ADDR, 32'd0, 2'($urandom_range(0, 3)), -1);
            else
              do_ls(1'($urandom_range(0, 1)), 32'h0000_2000 + 32'($urandom_range(0, 60)),
                    $urandom, 2'($urandom_range(0, 3)), -1);
          end
        join
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 rdy_in = ($urandom_range(0, 7) != 0);
        end
        rdy_in = 1'b1;
      end
    join

    repeat (4) @(posedge clk);
    #1;
    check("queues_drained", 32'(if_exp_q.size() + ls_exp_q.size() + wr_exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
